regfile_sb: RTL and testbench

Parametrised register file with a built-in scoreboard. It is the next-generation replacement for the fixed 32x32, 2-read-port register file in the current datapath. It adds a configurable number of read ports, write-to-read bypass, and per-register busy tracking. The scoreboard lets a multi-cycle or pipelined datapath stall instruction issue on RAW and WAW hazards. It sits between decode/CONTROL (issue side) and the ALU/writeback stage.

---
 rtl/regfile_sb.sv | 139 +++++++++++++
 tb/tb_regfile_sb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Parametrised register file with NRP combinational read ports,
//            write-through bypass and a per-register busy scoreboard that
//            stalls issue on RAW and WAW hazards.
//            Optional macro REGFILE_SB_STATS_EN adds saturating stall and
//            write counters (stat_stall_cnt, stat_wr_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rp_addr,
  input  logic [NRP-1:0]      rp_req,
  output logic [NRP*XLEN-1:0] rp_data,
  output logic [NRP-1:0]      rp_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic                iss_wr,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ok,
  output logic                stall
`ifdef REGFILE_SB_STATS_EN
  ,
  output logic [31:0]         stat_stall_cnt,
  output logic [31:0]         stat_wr_cnt
`endif
);

  // Register count widened by one bit so it can be compared with an address.
  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // An address is "real" when it is nonzero and names an existing register;
  // x0 and out-of-range addresses read 0, are never busy and drop writes.
  logic w_wr_real;
  logic w_rd_real;
  logic w_wr_hits_rd;
  logic w_raw;
  logic w_waw;

  assign w_wr_real    = wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < NREG_W);
  assign w_rd_real    = (iss_rd != '0) && ({1'b0, iss_rd} < NREG_W);
  assign w_wr_hits_rd = wr_en && (wr_addr == iss_rd);

  // Per-port read path: bypass a same-cycle writeback, which also resolves busy.
  for (genvar i = 0; i < NRP; i++) begin : g_rp
    logic [AW-1:0] w_addr;
    logic          w_real;
    logic          w_hit;

    assign w_addr = rp_addr[i*AW +: AW];
    assign w_real = (w_addr != '0) && ({1'b0, w_addr} < NREG_W);
    assign w_hit  = wr_en && (wr_addr == w_addr);

    assign rp_data[i*XLEN +: XLEN] = !w_real ? '0 :
                                     (w_hit ? wr_data : regs_q[w_addr]);
    assign rp_busy[i] = w_real && busy_q[w_addr] && !w_hit;
  end

  // Hazard detection: a source operand still in flight (RAW) or a destination
  // with an outstanding producer (WAW) blocks issue.
  assign w_raw  = |(rp_req & rp_busy);
  assign w_waw  = iss_wr && w_rd_real && busy_q[iss_rd] && !w_wr_hits_rd;
  assign stall  = iss_en && (w_raw || w_waw);
  assign iss_ok = iss_en && !stall;

  // Next-state: writeback stores data and clears busy; an accepted issue sets
  // busy afterwards so a simultaneous new producer keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (w_wr_real) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_ok && iss_wr && w_rd_real) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  // Register array and scoreboard state; reset clears everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

`ifdef REGFILE_SB_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] wr_cnt_q;
  logic [31:0] wr_cnt_d;

  // Saturating event counters: hold at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (w_wr_real && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      wr_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_wr_cnt    = wr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Scoreboard bench for regfile_sb. The stimulus process drives a
//            cycle, predicts the combinational outputs from a plain array
//            model and queues the prediction; a monitor compares on the
//            falling edge. NREG is set below 2**AW so out-of-range addresses
//            are exercised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 24;
  localparam int AW   = 5;
  localparam int NRP  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRP*AW-1:0]   rp_addr;
  logic [NRP-1:0]      rp_req;
  logic [NRP*XLEN-1:0] rp_data;
  logic [NRP-1:0]      rp_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic                iss_wr;
  logic [AW-1:0]       iss_rd;
  logic                iss_ok;
  logic                stall;
`ifdef REGFILE_SB_STATS_EN
  logic [31:0]         stat_stall_cnt;
  logic [31:0]         stat_wr_cnt;
`endif

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP)) dut (
    .clk     (clk),
    .rst     (rst),
    .rp_addr (rp_addr),
    .rp_req  (rp_req),
    .rp_data (rp_data),
    .rp_busy (rp_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .iss_en  (iss_en),
    .iss_wr  (iss_wr),
    .iss_rd  (iss_rd),
    .iss_ok  (iss_ok),
    .stall   (stall)
`ifdef REGFILE_SB_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_wr_cnt    (stat_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic [NRP*XLEN-1:0] data;
    logic [NRP-1:0]      busy;
    logic                ok;
    logic                stl;
    logic [31:0]         sc;
    logic [31:0]         wc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [XLEN-1:0] mregs [NREG];
  bit              mbusy [NREG];
  int unsigned     m_stall_cnt;
  int unsigned     m_wr_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: every falling edge with a pending prediction is compared.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".rp_data"}, 128'(rp_data), 128'(e.data));
        chk({e.name, ".rp_busy"}, 128'(rp_busy), 128'(e.busy));
        chk({e.name, ".iss_ok"},  128'(iss_ok),  128'(e.ok));
        chk({e.name, ".stall"},   128'(stall),   128'(e.stl));
`ifdef REGFILE_SB_STATS_EN
        chk({e.name, ".stat_stall"}, 128'(stat_stall_cnt), 128'(e.sc));
        chk({e.name, ".stat_wr"},    128'(stat_wr_cnt),    128'(e.wc));
`endif
      end
    end
  end

  function automatic bit real_reg(input int a);
    return (a != 0) && (a < NREG);
  endfunction

  // Drive one cycle, predict its outputs, then advance the model past the edge.
  task automatic cyc(input string nm, input bit r,
                     input int a0, input int a1, input bit [1:0] req,
                     input bit we, input int wa, input logic [XLEN-1:0] wd,
                     input bit ie, input bit iw, input int rd);
    exp_t e;
    int   addr [NRP];
    bit   raw, waw;
    @(posedge clk);
    #1;
    rst     = r;
    rp_addr = {AW'(a1), AW'(a0)};
    rp_req  = req;
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = wd;
    iss_en  = ie;
    iss_wr  = iw;
    iss_rd  = AW'(rd);
    addr[0] = a0;
    addr[1] = a1;

    e.name = nm;
    e.data = '0;
    e.busy = '0;
    raw    = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      bit hit;
      hit = we && (wa == addr[i]);
      if (real_reg(addr[i])) begin
        e.data[i*XLEN +: XLEN] = hit ? wd : mregs[addr[i]];
        e.busy[i]              = mbusy[addr[i]] && !hit;
      end
      if (req[i] && e.busy[i]) raw = 1'b1;
    end
    waw   = iw && real_reg(rd) && mbusy[rd] && !(we && wa == rd);
    e.stl = ie && (raw || waw);
    e.ok  = ie && !e.stl;
    e.sc  = m_stall_cnt;
    e.wc  = m_wr_cnt;
    if (!r) exp_q.push_back(e);

    if (r) begin
      for (int k = 0; k < NREG; k++) begin
        mregs[k] = '0;
        mbusy[k] = 1'b0;
      end
      m_stall_cnt = 0;
      m_wr_cnt    = 0;
    end else begin
      if (e.stl) m_stall_cnt++;
      if (we && real_reg(wa)) begin
        mregs[wa] = wd;
        mbusy[wa] = 1'b0;
        m_wr_cnt++;
      end
      if (e.ok && iw && real_reg(rd)) mbusy[rd] = 1'b1;
    end
  endtask

  task automatic idle(input string nm, input int a0, input int a1);
    cyc(nm, 0, a0, a1, 2'b00, 0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; rp_addr = '0; rp_req = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; iss_en = 1'b0; iss_wr = 1'b0; iss_rd = '0;
    for (int k = 0; k < NREG; k++) begin
      mregs[k] = 32'hFFFF_FFFF;
      mbusy[k] = 1'b1;
    end
    m_stall_cnt = 0;
    m_wr_cnt    = 0;

    // Reset and x0 behaviour
    cyc("rst0", 1, 0, 0, 2'b00, 0, 0, '0, 0, 0, 0);
    cyc("rst1", 1, 0, 0, 2'b00, 0, 0, '0, 0, 0, 0);
    idle("reset_x0_x1", 0, 1);
    idle("reset_x2_x3", 2, 3);
    cyc("wr_x0", 0, 0, 0, 2'b11, 1, 0, 32'hDEADBEEF, 0, 0, 0);
    idle("rd_x0", 0, 0);

    // Bypass then stored value
    cyc("bypass_x5", 0, 5, 5, 2'b00, 1, 5, 32'h12345678, 0, 0, 0);
    idle("stored_x5", 5, 0);

    // RAW stall released by writeback
    cyc("iss_x6", 0, 0, 0, 2'b00, 0, 0, '0, 1, 1, 6);
    cyc("raw_x6", 0, 6, 0, 2'b01, 0, 0, '0, 1, 0, 0);
    cyc("raw_x6_wb", 0, 6, 0, 2'b01, 1, 6, 32'h000000A5, 1, 0, 0);

    // WAW stall, then set-wins on same-cycle writeback and issue
    cyc("iss_x7", 0, 0, 0, 2'b00, 0, 0, '0, 1, 1, 7);
    cyc("waw_x7", 0, 0, 0, 2'b00, 0, 0, '0, 1, 1, 7);
    cyc("waw_x7_wb", 0, 7, 0, 2'b00, 1, 7, 32'h77, 1, 1, 7);
    cyc("x7_still_busy", 0, 7, 0, 2'b01, 0, 0, '0, 1, 0, 0);

    // Reset discards pending busy bits
    cyc("iss_x8", 0, 0, 0, 2'b00, 0, 0, '0, 1, 1, 8);
    cyc("iss_x9", 0, 0, 0, 2'b00, 0, 0, '0, 1, 1, 9);
    cyc("rst_mid", 1, 0, 0, 2'b00, 1, 8, 32'h88, 0, 0, 0);
    cyc("after_rst_x8", 0, 8, 9, 2'b11, 0, 0, '0, 1, 0, 0);

    // Out-of-range register
    cyc("wr_x30", 0, 0, 0, 2'b00, 1, 30, 32'h30303030, 1, 1, 30);
    cyc("rd_x30", 0, 30, 0, 2'b01, 0, 0, '0, 1, 1, 30);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit r;
      r = ($urandom_range(0, 63) == 0);
      cyc("rand", r, $urandom_range(0, 31), $urandom_range(0, 31),
          2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4),
          $urandom_range(0, 31), $urandom, ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) < 6), $urandom_range(0, 31));
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
